// File: rtl/bubble_sort_seq.sv
// Odd-even transposition sorter: loads one vector, runs one compare-exchange phase per clock, presents the result.
// Latency: input_num SORT cycles after the accept edge (2..input_num with BUBBLE_SORT_EARLY_EXIT_EN defined).
// Backpressure: in_ready only in IDLE; result is held in DONE until out_ready; no same-cycle reload after unload.
module bubble_sort_seq #(
    parameter int input_num = 4,
    parameter int DW        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [input_num*DW-1:0] din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [input_num*DW-1:0] dout,
    output logic                    busy
);

    localparam int W   = input_num * DW;
    localparam int PCW = $clog2(input_num + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [W-1:0]     data_q;
    logic [W-1:0]     data_d;
    logic [W-1:0]     dout_q;
    logic             phase_q;
    logic [PCW-1:0]   pass_cnt_q;
    logic             last_pass;
    logic             sort_exit;

    // One compare-exchange phase applied to the data register. Phase 0 pairs start at
    // the top lane (input_num-1), phase 1 one lane lower; uncovered lanes pass through.
    // Strict '>' keeps equal lanes in place.
    always_comb begin
        data_d = data_q;
        for (int i = input_num - 1; i >= 1; i--) begin
            if ((((input_num - 1 - i) % 2) == 1) == phase_q) begin
                if (data_q[DW*i +: DW] > data_q[DW*(i-1) +: DW]) begin
                    data_d[DW*i +: DW]     = data_q[DW*(i-1) +: DW];
                    data_d[DW*(i-1) +: DW] = data_q[DW*i +: DW];
                end
            end
        end
    end

    assign last_pass = (pass_cnt_q == PCW'(input_num - 1));

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    // A swap always changes the vector (strict compare), so a changed vector means a swap.
    logic swap_any;
    logic quiet_q;

    assign swap_any  = (data_d != data_q);
    // Two consecutive quiet phases cover every adjacent pair, so the vector is sorted.
    assign sort_exit = last_pass || (!swap_any && quiet_q);

    // Remember whether the previous phase of this vector made no swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            quiet_q <= 1'b0;
        end else if (state_q == SORT) begin
            quiet_q <= !swap_any;
        end
    end
`else
    assign sort_exit = last_pass;
`endif

    // Control FSM: load on accept, one phase per SORT cycle, hold result until unloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            dout_q     <= '0;
            phase_q    <= 1'b0;
            pass_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= din;
                        phase_q    <= 1'b0;
                        pass_cnt_q <= '0;
                        state_q    <= SORT;
                    end
                end
                SORT: begin
                    data_q     <= data_d;
                    phase_q    <= ~phase_q;
                    pass_cnt_q <= pass_cnt_q + PCW'(1);
                    if (sort_exit) begin
                        dout_q  <= data_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SORT);
    assign dout      = dout_q;

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Bench for bubble_sort_seq: 4-lane and 5-lane instances, scoreboard of reference-sorted vectors.
// Expected latency follows BUBBLE_SORT_EARLY_EXIT_EN when it is defined for the build.
// Covers reset, sorted/reverse/duplicate/random vectors, output backpressure and mid-sort reset.
module tb_bubble_sort_seq;

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] din, dout;
    logic        in_valid5, in_ready5, out_valid5, out_ready5, busy5;
    logic [39:0] din5, dout5;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb4[$];
    logic [39:0] sb5[$];

    always #5 clk = ~clk;

    bubble_sort_seq #(.input_num(4), .DW(8)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
    );

    bubble_sort_seq #(.input_num(5), .DW(8)) u5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5), .din(din5),
        .out_valid(out_valid5), .out_ready(out_ready5), .dout(dout5), .busy(busy5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain selection sort, lane 0 largest.
    function automatic logic [39:0] model(input logic [39:0] v, input int n);
        logic [7:0]  a [5];
        logic [7:0]  t;
        logic [39:0] r;
        for (int i = 0; i < 5; i++) a[i] = (i < n) ? v[8*i +: 8] : 8'h00;
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (a[j] > a[i]) begin
                    t = a[i]; a[i] = a[j]; a[j] = t;
                end
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = a[i];
        return r;
    endfunction

    // Wait for in_ready, present one vector for exactly one accept edge, push expectation.
    task automatic send4(input logic [31:0] d);
        int guard;
        logic [39:0] e;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        din      = d;
        e        = model({8'h00, d}, 4);
        sb4.push_back(e[31:0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid rises.
    task automatic wait_valid4(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("out_valid_timeout", out_valid, 1'b1);
    endtask

    // Check latency (exp_lat < 0: any legal latency for this build), data, and the unload handshake.
    task automatic collect4(input string tag, input int exp_lat);
        int lat;
        logic [31:0] e;
        wait_valid4(lat);
        if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
        else chk({tag, "_lat_range"}, EE ? (lat >= 2 && lat <= 4) : (lat == 4), 1'b1);
        chk({tag, "_in_ready_done"}, in_ready, 1'b0);
        e = (sb4.size() > 0) ? sb4.pop_front() : 32'hxxxxxxxx;
        chk({tag, "_dout"}, dout, e);
        @(posedge clk); #1;
        chk({tag, "_out_valid_after"}, out_valid, 1'b0);
        chk({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] snap;
        logic [31:0] rv;
        logic [39:0] e5;
        logic        ov_seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = '0;
        in_valid5 = 1'b0; out_ready5 = 1'b1; din5 = '0;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dout", dout, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Directed vectors.
        send4(32'h04030201); collect4("reverse", 4);
        chk("reverse_const", dout, 32'h01020304);
        send4(32'h01020304); collect4("sorted", EE ? 2 : 4);
        send4(32'h05010501); collect4("dups", 4);
        chk("dups_const", dout, 32'h01010505);

        // Random vectors, including narrow ranges to force duplicate lanes.
        for (int k = 0; k < 6; k++) begin
            rv = $urandom();
            if (k % 2 == 1)
                for (int l = 0; l < 4; l++) rv[8*l +: 8] = 8'($urandom_range(0, 3));
            send4(rv); collect4("random", -1);
        end

        // Backpressure: hold the result while a new vector is offered.
        out_ready = 1'b0;
        send4(32'h33112244);
        wait_valid4(lat);
        snap = (sb4.size() > 0) ? sb4.pop_front() : 32'hxxxxxxxx;
        chk("bp_dout", dout, snap);
        in_valid = 1'b1; din = 32'hdeadbeef;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_dout", dout, snap);
            chk("bp_hold_in_ready", in_ready, 1'b0);
            chk("bp_hold_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_release_out_valid", out_valid, 1'b0);
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_no_reload", busy, 1'b0);
        @(posedge clk); #1;
        chk("bp_still_idle", busy, 1'b0);

        // Asynchronous reset during the second SORT cycle discards the vector.
        send4(32'h04030201);
        void'(sb4.pop_front());
        @(posedge clk); #1;
        chk("mid_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_dout", dout, 32'h0);
        chk("mid_rst_busy", busy, 1'b0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        ov_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            ov_seen = ov_seen | out_valid;
        end
        chk("mid_rst_no_stale", ov_seen, 1'b0);

        // Five lanes: already-sorted and reversed vectors.
        for (int k = 0; k < 2; k++) begin
            din5 = (k == 0) ? 40'h0102030405 : 40'h0504030201;
            in_valid5 = 1'b1;
            sb5.push_back(model(din5, 5));
            @(posedge clk); #1;
            in_valid5 = 1'b0;
            lat = 0;
            while (!out_valid5 && lat < 100) begin
                @(posedge clk); #1; lat++;
            end
            chk("n5_out_valid", out_valid5, 1'b1);
            chk("n5_lat", lat, (k == 0 && EE) ? 2 : 5);
            e5 = (sb5.size() > 0) ? sb5.pop_front() : 40'hxxxxxxxxxx;
            chk("n5_dout", dout5, e5);
            chk("n5_dout_const", dout5, 40'h0102030405);
            @(posedge clk); #1;
            chk("n5_in_ready_after", in_ready5, 1'b1);
        end

        chk("sb4_empty", sb4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
